// File: rtl/rv_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_control
// Purpose  : Multi-cycle RV32I control FSM. Sequences FETCH/DECODE/EXEC/MEM/
//            WB/BRANCH/JUMP, owns the memory request handshake and a bus
//            timeout counter. All outputs are combinational from state, IR
//            and inputs.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mc_control #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        cmp_true,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        aluout_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal_instr,
    output logic        bus_err,
    output logic        instr_retired,
    output logic [2:0]  state
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_BRANCH = 3'd5;
    localparam logic [2:0] c_JUMP   = 3'd6;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_S    = 7'b0100011;
    localparam logic [6:0] c_OP_SB   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;

    // Last count value before a timeout fires (meaningless when disabled).
    localparam logic [CNT_W-1:0] c_LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);
    localparam bit               c_TO_EN    = (WAIT_LIMIT != 0);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       w_next;
    logic [6:0]       w_opcode;
    logic             w_mem_phase;
    logic             w_timeout;
    logic             w_unused_instr;

    assign w_opcode       = instr[6:0];
    // Function fields are decoded by the ALU itself, not here.
    assign w_unused_instr = &{1'b0, instr[31:7]};
    assign w_mem_phase    = (r_state == c_FETCH) || (r_state == c_MEM);
    // mem_ready in the limit cycle wins over the timeout.
    assign w_timeout      = c_TO_EN && w_mem_phase && !mem_ready && (r_cnt == c_LIMIT_M1);
    assign state          = r_state;

    // Next-state and control-output decode; everything forced low in reset.
    always_comb begin
        w_next        = r_state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        aluout_write  = 1'b0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        illegal_instr = 1'b0;
        bus_err       = w_timeout;
        instr_retired = 1'b0;
        case (r_state)
            c_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = c_DECODE;
                end
            end
            c_DECODE: begin
                alu_src_a    = 2'd1;
                alu_src_b    = 2'd1;
                aluout_write = 1'b1;
                case (w_opcode)
                    c_OP_R, c_OP_I, c_OP_LOAD, c_OP_S: w_next = c_EXEC;
                    c_OP_SB:                           w_next = c_BRANCH;
                    c_OP_JAL, c_OP_JALR:               w_next = c_JUMP;
                    c_OP_LUI:                          w_next = c_WB;
                    default: begin
                        // PC was already advanced in FETCH; just drop it.
                        illegal_instr = 1'b1;
                        w_next        = c_FETCH;
                    end
                endcase
            end
            c_EXEC: begin
                alu_src_a    = 2'd2;
                aluout_write = 1'b1;
                case (w_opcode)
                    c_OP_R: begin
                        alu_op = 2'd1;
                        w_next = c_WB;
                    end
                    c_OP_I: begin
                        alu_src_b = 2'd1;
                        alu_op    = 2'd1;
                        w_next    = c_WB;
                    end
                    c_OP_LOAD, c_OP_S: begin
                        alu_src_b = 2'd1;
                        w_next    = c_MEM;
                    end
                    default: w_next = c_FETCH;
                endcase
            end
            c_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (w_opcode == c_OP_S);
                if (mem_ready) begin
                    if (w_opcode == c_OP_S) begin
                        instr_retired = 1'b1;
                        w_next        = c_FETCH;
                    end else begin
                        w_next = c_WB;
                    end
                end else if (w_timeout) begin
                    // Abandon the access; nothing is written back.
                    w_next = c_FETCH;
                end
            end
            c_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = c_FETCH;
                if (w_opcode == c_OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if (w_opcode == c_OP_LUI) begin
                    wb_sel = 2'd2;
                end
            end
            c_BRANCH: begin
                alu_src_a     = 2'd2;
                alu_op        = 2'd2;
                instr_retired = 1'b1;
                w_next        = c_FETCH;
                if (cmp_true) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd1;
                end
            end
            c_JUMP: begin
                // PC already holds the return address (written via wb_sel=3).
                reg_write     = 1'b1;
                wb_sel        = 2'd3;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                w_next        = c_FETCH;
                if (w_opcode == c_OP_JALR) begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    pc_src    = 2'd2;
                end else begin
                    pc_src = 2'd1;
                end
            end
            default: w_next = c_FETCH;
        endcase
        if (!n_rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            addr_sel      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 2'd0;
            aluout_write  = 1'b0;
            alu_src_a     = 2'd0;
            alu_src_b     = 2'd0;
            alu_op        = 2'd0;
            reg_write     = 1'b0;
            wb_sel        = 2'd0;
            illegal_instr = 1'b0;
            bus_err       = 1'b0;
            instr_retired = 1'b0;
        end
    end

    // State register and bus-wait counter (cleared on ready, timeout or state change).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || mem_ready || w_timeout || !w_mem_phase) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
